// File: rtl/alu_share_ctrl.sv
// Two-requester shared ALU: round-robin grant, one-cycle execute, result held
// until the consumer takes it.
module alu_share_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_c,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    // state | meaning
    // IDLE  | waiting for a request, grants one requester
    // EXEC  | computing from captured operands
    // RESP  | result valid, holding until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         id_q, id_d;
    logic [N-1:0] rsp_c_q, rsp_c_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_id_q, rsp_id_d;

    logic         any_valid;
    logic         gnt1;
    logic [N:0]   sum;
    logic [N-1:0] res;
    logic         c_flag;
    logic         v_flag;

    // A tie goes to requester 1 only when requester 0 was granted last.
    assign any_valid = req0_valid | req1_valid;
    assign gnt1      = req1_valid & (~req0_valid | ~last_q);

    always_comb begin
        sum    = '0;
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op_q)
            3'b000: res = a_q & b_q;
            3'b001: res = a_q | b_q;
            3'b010: res = a_q ^ b_q;
            3'b011: begin
                sum    = {1'b0, a_q} + {1'b0, b_q};
                res    = sum[N-1:0];
                c_flag = sum[N];
                v_flag = (a_q[N-1] == b_q[N-1]) && (res[N-1] != a_q[N-1]);
            end
            3'b100: begin
                sum    = {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1);
                res    = sum[N-1:0];
                c_flag = sum[N];
                v_flag = (a_q[N-1] != b_q[N-1]) && (res[N-1] != a_q[N-1]);
            end
            3'b101: res = ~a_q;
            3'b110: begin
                res    = {a_q[N-2:0], 1'b0};
                c_flag = a_q[N-1];
            end
            default: begin
                res    = {1'b0, a_q[N-1:1]};
                c_flag = a_q[0];
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_c_d     = rsp_c_q;
        rsp_flags_d = rsp_flags_q;
        rsp_id_d    = rsp_id_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = ~gnt1;
                    req1_ready = gnt1;
                    op_d       = gnt1 ? req1_op : req0_op;
                    a_d        = gnt1 ? req1_a  : req0_a;
                    b_d        = gnt1 ? req1_b  : req0_b;
                    id_d       = gnt1;
                    last_d     = gnt1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_c_d     = res;
                rsp_flags_d = {res[N-1], (res == '0), c_flag, v_flag};
                rsp_id_d    = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_c     = rsp_c_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl (N=4): opcodes/flags, latency, stall,
// round-robin arbitration and reset abort.
module tb_alu_share_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, busy;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_c;
    logic [3:0]   rsp_flags;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    alu_share_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction with hand-computed result and flags.
    task automatic run_op(input string tag, input logic rid, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ec, input logic [3:0] ef);
        if (rid == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'(rid == 1'b0));
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'(rid));
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = ~op; req1_op = ~op;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        #1;
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
        tick;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_c"}, 32'(rsp_c), 32'(ec));
        chk({tag, "_flags"}, 32'(rsp_flags), 32'(ef));
        chk({tag, "_id"}, 32'(rsp_id), 32'(rid));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_c"}, 32'(rsp_c), 32'(ec));
    endtask

    initial begin
        // Reset with a pending request: nothing may be granted.
        req0_valid = 1'b1;
        tick;
        tick;
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c", 32'(rsp_c), 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick;

        run_op("and",   1'b0, 3'b000, 4'hC, 4'hA, 4'h8, 4'b1000);
        run_op("add_v", 1'b1, 3'b011, 4'h7, 4'h1, 4'h8, 4'b1001);
        run_op("add_c", 1'b0, 3'b011, 4'hF, 4'h1, 4'h0, 4'b0110);
        run_op("sub_z", 1'b1, 3'b100, 4'h5, 4'h5, 4'h0, 4'b0110);
        run_op("sub_b", 1'b0, 3'b100, 4'h0, 4'h1, 4'hF, 4'b1000);
        run_op("shr",   1'b1, 3'b111, 4'h3, 4'hF, 4'h1, 4'b0010);
        run_op("or",    1'b0, 3'b001, 4'h5, 4'hA, 4'hF, 4'b1000);
        run_op("xor",   1'b1, 3'b010, 4'h6, 4'h6, 4'h0, 4'b0100);
        run_op("not",   1'b0, 3'b101, 4'h5, 4'h0, 4'hA, 4'b1000);
        run_op("shl",   1'b1, 3'b110, 4'h9, 4'h0, 4'h2, 4'b0010);

        // Stalled response while both requesters hammer new inputs.
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'h8; req1_b = 4'h1;
        #1;
        chk("stall_rdy1", 32'(req1_ready), 32'd1);
        tick;
        req1_valid = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_op = 3'($urandom); req1_op = 3'($urandom);
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_c", 32'(rsp_c), 32'h7);
            chk("stall_flags", 32'(rsp_flags), 32'b0011);
            chk("stall_id", 32'(rsp_id), 32'd1);
            chk("stall_rdy0", 32'(req0_ready), 32'd0);
            chk("stall_rdy1b", 32'(req1_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("stall_idle_busy", 32'(busy), 32'd0);
        chk("stall_idle_valid", 32'(rsp_valid), 32'd0);

        // Round robin from reset with both requesters always valid.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        req0_op = 3'b011; req0_a = 4'h1; req0_b = 4'h2;
        req1_op = 3'b010; req1_a = 4'hF; req1_b = 4'h5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rdy0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("rr_rdy1", 32'(req1_ready), 32'((i % 2) == 1));
            tick;
            tick;
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(i % 2));
            chk("rr_c", 32'(rsp_c), ((i % 2) == 0) ? 32'h3 : 32'hA);
            chk("rr_resp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during EXEC after a req0 grant: aborted, and req0 wins the next tie.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'hF; req0_b = 4'hF;
        #1;
        chk("abort_rdy0", 32'(req0_ready), 32'd1);
        tick;
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("abort_rst_rdy", 32'({req0_ready, req1_ready}), 32'd0);
        tick;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", 32'(rsp_flags), 32'd0);
        chk("abort_c", 32'(rsp_c), 32'd0);
        rst_n = 1'b1;
        req0_op = 3'b000; req0_a = 4'hC; req0_b = 4'hA;
        req1_op = 3'b001; req1_a = 4'h1; req1_b = 4'h2;
        #1;
        chk("tie_rdy0", 32'(req0_ready), 32'd1);
        chk("tie_rdy1", 32'(req1_ready), 32'd0);
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick;
        chk("tie_valid", 32'(rsp_valid), 32'd1);
        chk("tie_id", 32'(rsp_id), 32'd0);
        chk("tie_c", 32'(rsp_c), 32'h8);
        chk("tie_flags", 32'(rsp_flags), 32'b1000);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("tie_done", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
